// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern generator.
//   mode_e : pattern selection as carried on the mode / mode_active ports
//   dir_e  : sweep direction used by the SCAN and BREATHE generators
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_OFF     = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/led_prescaler.sv
// Free-running prescaler that produces one pattern step every 2^WIDTH
// enabled cycles.
//   sysclock  : system clock, rising edge
//   sys_rst_n : asynchronous active-low reset (already release-synchronised)
//   enable    : count enable; low holds the count and suppresses step
//   step      : high on the enabled cycle where the count is all-ones
module led_prescaler #(
  parameter int unsigned WIDTH = 24
) (
  input  logic sysclock,
  input  logic sys_rst_n,
  input  logic enable,
  output logic step
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge sysclock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  // Combinational so the pattern logic acts on the same edge the count wraps.
  assign step = enable && (count == '1);

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: COUNT, SCAN (bouncing dot), BREATHE (triangle PWM)
// and OFF patterns, stepped by a prescaler.
//   sysclock    : system clock, rising edge
//   sys_rst_n   : asynchronous active-low reset, released synchronously inside
//   mode        : requested pattern, sampled only on step cycles
//   pause       : freezes prescaler and pattern state (PWM keeps running)
//   leds        : registered LED drive, bit 0 = LED1
//   tick        : registered one-cycle pulse per pattern step
//   mode_active : pattern currently displayed
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int unsigned NUM_LEDS   = 8,
  parameter int unsigned PRESCALE_W = 24,
  parameter int unsigned PWM_W      = 8
) (
  input  logic                sysclock,
  input  logic                sys_rst_n,
  input  logic [1:0]          mode,
  input  logic                pause,
  output logic [NUM_LEDS-1:0] leds,
  output logic                tick,
  output logic [1:0]          mode_active
);

  localparam int unsigned      POS_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_LEDS - 1);
  localparam logic [PWM_W-1:0] LVL_MAX = '1;

  // Async assert, two-flop synchronous release.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge sysclock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  logic step;

  led_prescaler #(
    .WIDTH(PRESCALE_W)
  ) u_prescaler (
    .sysclock (sysclock),
    .sys_rst_n(rst_n),
    .enable   (!pause),
    .step     (step)
  );

  mode_e               mode_req;
  mode_e               mode_cur;
  logic [NUM_LEDS-1:0] count;
  logic [POS_W-1:0]    pos;
  dir_e                scan_dir;
  logic [PWM_W-1:0]    level;
  dir_e                level_dir;
  logic [PWM_W-1:0]    pwm_cnt;
  logic [NUM_LEDS-1:0] scan_onehot;

  assign mode_req    = mode_e'(mode);
  assign mode_active = mode_cur;

  // Pattern state: a step either loads a new mode (and restarts it) or
  // advances the active mode; the two never happen on the same step.
  always_ff @(posedge sysclock or negedge rst_n) begin
    if (!rst_n) begin
      mode_cur  <= MODE_OFF;
      tick      <= 1'b0;
      count     <= '0;
      pos       <= '0;
      scan_dir  <= DIR_UP;
      level     <= '0;
      level_dir <= DIR_UP;
    end else begin
      tick <= step;
      if (step) begin
        if (mode_req != mode_cur) begin
          mode_cur <= mode_req;
          case (mode_req)
            MODE_COUNT: count <= '0;
            MODE_SCAN: begin
              pos      <= '0;
              scan_dir <= DIR_UP;
            end
            MODE_BREATHE: begin
              level     <= '0;
              level_dir <= DIR_UP;
            end
            default: ;
          endcase
        end else begin
          case (mode_cur)
            MODE_COUNT: count <= count + NUM_LEDS'(1);
            MODE_SCAN: begin
              // A single LED has nowhere to move.
              if (POS_MAX != '0) begin
                if (scan_dir == DIR_UP) begin
                  pos <= pos + POS_W'(1);
                  if (pos == POS_MAX - POS_W'(1)) scan_dir <= DIR_DOWN;
                end else begin
                  pos <= pos - POS_W'(1);
                  if (pos == POS_W'(1)) scan_dir <= DIR_UP;
                end
              end
            end
            MODE_BREATHE: begin
              if (level_dir == DIR_UP) begin
                level <= level + PWM_W'(1);
                if (level == LVL_MAX - PWM_W'(1)) level_dir <= DIR_DOWN;
              end else begin
                level <= level - PWM_W'(1);
                if (level == PWM_W'(1)) level_dir <= DIR_UP;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    scan_onehot = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      scan_onehot[i] = (pos == POS_W'(i));
    end
  end

  // Registered output mux; PWM runs every cycle so BREATHE keeps glowing
  // while paused.
  always_ff @(posedge sysclock or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      leds    <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      case (mode_cur)
        MODE_COUNT:   leds <= count;
        MODE_SCAN:    leds <= scan_onehot;
        MODE_BREATHE: leds <= {NUM_LEDS{pwm_cnt < level}};
        default:      leds <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
module tb_led_pattern_gen;

  logic       sysclock = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic [1:0] mode = 2'd3;
  logic       pause = 1'b0;
  logic [3:0] leds;
  logic       tick;
  logic [1:0] mode_active;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  led_pattern_gen #(
    .NUM_LEDS  (4),
    .PRESCALE_W(2),
    .PWM_W     (3)
  ) dut (
    .sysclock   (sysclock),
    .sys_rst_n  (sys_rst_n),
    .mode       (mode),
    .pause      (pause),
    .leds       (leds),
    .tick       (tick),
    .mode_active(mode_active)
  );

  always #5 sysclock = ~sysclock;

  // ---------------- behavioural model ----------------
  // k counts steps since the active mode was loaded; every pattern is a
  // plain function of k (and of the free-running PWM phase).
  int         sync_cnt = 0;
  int         pre = 0;
  int         pwm = 0;
  int         k = 0;
  int         mact = 3;
  bit         exp_tick = 1'b0;
  logic [3:0] exp_leds = 4'h0;
  bit         step_now;

  function automatic int tri_wave(int n, int top);
    int p;
    p = n % (2 * top);
    return (p <= top) ? p : 2 * top - p;
  endfunction

  function automatic logic [3:0] pattern(int m, int n, int ph);
    case (m)
      0:       return 4'(n % 16);
      1:       return 4'(1 << tri_wave(n, 3));
      2:       return (ph < tri_wave(n, 7)) ? 4'hF : 4'h0;
      default: return 4'h0;
    endcase
  endfunction

  always @(posedge sysclock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_cnt = 0;
      pre      = 0;
      pwm      = 0;
      k        = 0;
      mact     = 3;
      exp_tick = 1'b0;
      exp_leds = 4'h0;
    end else if (sync_cnt < 2) begin
      sync_cnt++;
    end else begin
      exp_leds = pattern(mact, k, pwm);
      step_now = !pause && (pre == 3);
      exp_tick = step_now;
      pwm = (pwm + 1) % 8;
      if (!pause) pre = (pre + 1) % 4;
      if (step_now) begin
        if (int'(mode) != mact) begin
          mact = int'(mode);
          k    = 0;
        end else begin
          k++;
        end
      end
    end
  end

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge sysclock) begin
    if (chk_en) begin
      check("model_leds", int'(leds), int'(exp_leds));
      check("model_tick", int'(tick), int'(exp_tick));
      check("model_mode_active", int'(mode_active), mact);
    end
  end

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge sysclock);
      n++;
    end while (!exp_tick && n < 12);
    if (!exp_tick) begin
      tests++;
      fails++;
      $display("FAIL wait_tick: no step within %0d cycles at %0t", n, $time);
    end
  endtask

  task automatic wait_pre(int v);
    int n;
    n = 0;
    while (pre != v && n < 8) begin
      @(negedge sysclock);
      n++;
    end
  endtask

  task automatic async_reset(int hold);
    @(posedge sysclock);
    #2 sys_rst_n = 1'b0;
    #1;
    check("async_rst_leds", int'(leds), 0);
    check("async_rst_mode_active", int'(mode_active), 3);
    check("async_rst_tick", int'(tick), 0);
    repeat (hold) @(negedge sysclock);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] scan_seq [8];
    int kp, n, hi;
    scan_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    // Reset state
    #1 sys_rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge sysclock);
    check("reset_leds", int'(leds), 0);
    check("reset_tick", int'(tick), 0);
    check("reset_mode_active", int'(mode_active), 3);

    // COUNT: load then 1..15,0
    mode = 2'd0;
    sys_rst_n = 1'b1;
    wait_tick();
    check("count_load_mode", int'(mode_active), 0);
    @(negedge sysclock);
    check("count_load_leds", int'(leds), 0);
    for (int i = 1; i <= 16; i++) begin
      wait_tick();
      @(negedge sysclock);
      check("count_seq", int'(leds), i % 16);
    end
    for (int i = 1; i <= 5; i++) begin
      wait_tick();
      @(negedge sysclock);
    end
    check("count_at5", int'(leds), 5);

    // Pause mid-count
    repeat ($urandom_range(0, 2)) @(negedge sysclock);
    pause = 1'b1;
    kp = pre;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclock);
      check("pause_leds", int'(leds), 5);
      check("pause_tick", int'(tick), 0);
    end
    pause = 1'b0;
    n = 0;
    do begin
      @(negedge sysclock);
      n++;
    end while (!tick && n < 10);
    check("resume_latency", n, 4 - kp);
    @(negedge sysclock);
    check("resume_leds", int'(leds), 6);

    // Mode change then revert before the step: no change
    wait_pre(1);
    mode = 2'd1;
    @(negedge sysclock);
    mode = 2'd0;
    wait_tick();
    check("revert_mode", int'(mode_active), 0);
    @(negedge sysclock);
    check("revert_leds", int'(leds), 7);

    // Change 0->1 two cycles before a step
    wait_pre(2);
    mode = 2'd1;
    wait_tick();
    check("scan_load_mode", int'(mode_active), 1);
    @(negedge sysclock);
    check("scan_seq", int'(leds), int'(scan_seq[0]));
    for (int i = 1; i < 8; i++) begin
      wait_tick();
      @(negedge sysclock);
      check("scan_seq", int'(leds), int'(scan_seq[i]));
    end

    // Asynchronous reset mid-SCAN, then restart
    async_reset(2);
    wait_tick();
    check("post_rst_mode", int'(mode_active), 1);
    @(negedge sysclock);
    check("post_rst_leds", int'(leds), 1);

    // BREATHE: climb to level 7, freeze, measure duty
    mode = 2'd2;
    wait_tick();
    check("breathe_load_mode", int'(mode_active), 2);
    repeat (7) wait_tick();
    pause = 1'b1;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge sysclock);
      if (leds == 4'hF) hi++;
    end
    check("breathe_level7_duty", hi, 7);
    pause = 1'b0;
    repeat (7) wait_tick();
    pause = 1'b1;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge sysclock);
      if (leds != 4'h0) hi++;
    end
    check("breathe_level0_duty", hi, 0);
    pause = 1'b0;

    // Randomised traffic checked by the model
    for (int i = 0; i < 800; i++) begin
      @(negedge sysclock);
      pause = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) async_reset($urandom_range(1, 3));
    end

    @(negedge sysclock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 8, the number of LED outputs (1..32).
REQ-002 The block SHALL have parameter PRESCALE_W, default 24, the prescaler width; one pattern step occurs every 2^PRESCALE_W enabled cycles.
REQ-003 The block SHALL have parameter PWM_W, default 8, the breathe-mode PWM and brightness width.
REQ-004 Port: sysclock  input  1  single system clock; all logic on its rising edge.
REQ-005 Port: sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port: mode  input  2  requested pattern: 0 COUNT, 1 SCAN, 2 BREATHE, 3 OFF.
REQ-007 Port: pause  input  1  high freezes the prescaler and the pattern state.
REQ-008 Port: leds  output  NUM_LEDS  registered LED drive, bit 0 = LED1.
REQ-009 Port: tick  output  1  registered one-cycle pulse per pattern step.
REQ-010 Port: mode_active  output  2  mode currently being displayed.

Function
REQ-011 The prescaler SHALL increment by 1 each cycle while pause=0 and hold while pause=1, wrapping from all-ones to 0.
REQ-012 The block SHALL assert internal step for one cycle when the prescaler is all-ones and pause=0; tick SHALL equal step delayed by one register.
REQ-013 On a step with mode != mode_active, the block SHALL load mode_active=mode and reinitialise that mode's state; no pattern advance occurs on that step.
REQ-014 A mode change between steps SHALL have no effect until the next step; only the value of mode on the step cycle is sampled.
REQ-015 COUNT: an NUM_LEDS-bit counter SHALL increment by 1 per step, wrapping all-ones to 0; leds = counter. Init value 0.
REQ-016 SCAN: position pos and direction dir SHALL produce the sequence 0,1,..,N-1,N-2,..,1,0,1,..; dir flips on the step that reaches N-1 or 0; leds = one-hot(pos). Init pos=0, dir=up.
REQ-017 SCAN with NUM_LEDS=1 SHALL hold pos=0, leds=1.
REQ-018 BREATHE: level (PWM_W bits) SHALL step +1 per step up to 2^PWM_W-1, then -1 down to 0, then up again; endpoints each held for exactly one step. Init level=0, dir=up.
REQ-019 BREATHE: a PWM_W-bit PWM counter SHALL increment every cycle regardless of pause; all leds bits = (pwm_cnt < level).
REQ-020 OFF: leds SHALL be all zero; no pattern state is kept.
REQ-021 leds SHALL be registered; a pattern state change is visible on leds one cycle after the step cycle.
REQ-022 pause asserted SHALL freeze leds in COUNT/SCAN/OFF; in BREATHE level freezes while PWM continues.
REQ-023 Pause released SHALL resume the prescaler from its held value with no lost or extra step.

Reset
REQ-024 While sys_rst_n=0 the block SHALL hold: leds=0, tick=0, mode_active=3 (OFF), prescaler=0, pwm_cnt=0, all pattern state at init values.
REQ-025 Reset deassertion SHALL be synchronised to sysclock (async assert, sync release) inside the block.
REQ-026 Reset asserted mid-pattern SHALL return all state to REQ-024 values immediately, without waiting for a clock edge.

Structure
REQ-027 Mode encodings (MODE_COUNT, MODE_SCAN, MODE_BREATHE, MODE_OFF) SHALL reside in shared package led_pattern_pkg.
REQ-028 The prescaler and step generation SHALL be a sub-module led_prescaler (params WIDTH; ports sysclock, sys_rst_n, enable, step).
REQ-029 Pattern generators SHALL be in led_pattern_gen; the selected output is chosen by mode_active through a registered multiplexer.

Verification (bench uses NUM_LEDS=4, PRESCALE_W=2, PWM_W=3; step every 4 cycles)
REQ-030 Reset then mode=0 for 80 cycles -> first step loads mode_active=0, leds=0; subsequent steps give leds 1,2,..,15,0 (wrap) one cycle after each tick.
REQ-031 mode=1 -> after mode load, leds sequence 0001,0010,0100,1000,0100,0010,0001,0010 on consecutive steps.
REQ-032 mode=2, level driven to 7 -> leds high 7 of every 8 cycles; level 0 -> leds constantly 0; level sequence ..6,7,6..,1,0,1.
REQ-033 mode=0, pause=1 for 20 cycles mid-count at leds=5 -> leds stays 5, tick stays 0; after release next step gives 6 exactly 4-k cycles later, k = prescaler value at pause.
REQ-034 Change mode 0->1 two cycles before a step -> mode_active changes on that step, leds=0001; change then revert before step -> no mode change.
REQ-035 Assert sys_rst_n=0 asynchronously mid-SCAN between edges -> leds=0, mode_active=3 without a clock edge; after release, behaviour restarts per REQ-013.
